// File: rtl/gf_mult_serial.sv
// Bit-serial GF(2^M) multiplier, one bit of B per clock (MSB first), with an
// optional multiply-accumulate into an internal accumulator.
module gf_mult_serial #(
  parameter int         M    = 4,
  parameter logic [M:0] POLY = 5'b10011
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_a,
  input  logic [M-1:0] in_b,
  input  logic         in_acc,
  input  logic         acc_clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_data
);

  localparam int CW = $clog2(M);

  generate
    if (M < 2 || M > 16 || POLY[M] != 1'b1) begin : g_bad_params
      $error("gf_mult_serial: M must be 2..16 and POLY[M] must be 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [M-1:0]    a_q, a_d;
  logic [M-1:0]    b_q, b_d;
  logic            mode_q, mode_d;
  logic [M-1:0]    p_q, p_d;
  logic [M-1:0]    acc_q, acc_d;
  logic [M-1:0]    out_q, out_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [M-1:0]    p_step;
  logic [M-1:0]    result;

  // Multiply by x modulo the generator polynomial.
  function automatic logic [M-1:0] xt(input logic [M-1:0] p);
    xt = {p[M-2:0], 1'b0} ^ (p[M-1] ? POLY[M-1:0] : '0);
  endfunction

  assign p_step = xt(p_q) ^ (b_q[cnt_q] ? a_q : '0);
  assign result = mode_q ? (acc_q ^ p_step) : p_step;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    p_d     = p_q;
    acc_d   = acc_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // A clear on the accept edge lets the new operation start from zero.
        if (acc_clr) acc_d = '0;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          mode_d  = in_acc;
          p_d     = '0;
          cnt_d   = CW'(M - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        p_d   = p_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          out_d   = result;
          if (mode_q) acc_d = result;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      p_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      p_q     <= p_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/gf_mult_serial.md
Name: gf_mult_serial

Overview:
- Parametrised bit-serial GF(2^M) multiplier with an optional multiply-accumulate mode.
- Successor to the fixed GF(16) table-lookup multiplier.
- Used in the RS decoder datapath for syndrome, Chien and Forney arithmetic where area matters more than single-cycle latency.
- Processes one bit of B per clock, MSB first, with valid/ready handshakes on input and output.

Parameters:
- M, 4, symbol width in bits. Legal range 2..16.
- POLY, 5'b10011, field generator polynomial, width M+1. Bit M must be 1. Default is x^4+x+1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- in_a  input  M  operand A
- in_b  input  M  operand B
- in_acc  input  1  1 = result is acc XOR A*B; 0 = plain product
- acc_clr  input  1  clear accumulator (honoured in IDLE only)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_data  output  M  result symbol

Behaviour:
- Clocking and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset state: state=IDLE, in_ready=1, out_valid=0, out_data=0, acc=0, P=0, count=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch A, B, in_acc; clear P to 0; count=M-1; go to RUN.
  - acc_clr=1 in IDLE clears acc on that edge. If acc_clr and an accept occur on the same edge, the new operation accumulates from 0.
- RUN (exactly M cycles, in_ready=0):
  - Each edge: P <= xt(P) ^ (B[count] ? A : 0).
  - xt(P) = (P<<1)[M-1:0] ^ (P[M-1] ? POLY[M-1:0] : 0).
  - count decrements each edge. After the edge with count=0, go to DONE.
  - The result register is loaded on that same edge: out_data <= acc_mode ? (acc ^ Pfinal) : Pfinal. If acc_mode, acc <= the same value.
  - out_valid rises on the M-th rising edge after the accepting edge.
- DONE:
  - out_valid=1, in_ready=0.
  - out_data is held stable until out_valid&&out_ready. On that edge, out_valid <= 0 and state goes to IDLE.
  - No same-cycle re-accept. Minimum spacing between accepts is M+2 cycles.
- acc_clr outside IDLE is ignored.
- out_data keeps its last value after the handshake; it is only meaningful while out_valid=1.
- Constant latency: zero operands take the full M cycles.
- Arithmetic: all additions are XOR; no carries. P, A and acc are M bits.
- Reset mid-operation (RUN or DONE): immediate return to reset state. Partial result and acc are discarded; out_valid drops asynchronously.
- in_valid held high while in_ready=0: no effect; operands are not latched.
- Input changes during RUN: no effect, because operands are latched.
- Parameter violation (POLY[M]=0 or M outside 2..16): elaboration error.

Test Plan:
- Default params; accept A=2, B=8, in_acc=0 -> out_valid on 4th edge after accept, out_data=3. Also: 3*10 -> 13, 15*15 -> 10, 0*9 -> 0, 1*7 -> 7.
- Exhaustive: all 256 (A,B) pairs for M=4 against a software GF(16) model, in_acc=0. All match, each with latency exactly 4.
- Accumulate: pulse acc_clr in IDLE, then 2*8 with in_acc=1 -> 3; then 3*3 with in_acc=1 -> 6 (3^5); then 4*4 with in_acc=0 -> 3, acc still 6; then acc_clr plus accept 5*5 with in_acc=1 on the same edge -> 2.
- Backpressure: out_ready low for 5 cycles after out_valid -> out_data stable, in_ready stays 0, and an in_valid pulse is ignored. Raise out_ready -> handshake, IDLE next cycle, next accept succeeds.
- Reset mid-run: assert rst_n=0 two cycles into RUN -> out_valid=0, in_ready=1, out_data=0, acc=0 immediately. A new 2*8 afterwards -> 3.
- M=8, POLY=9'h11D: 0x80*0x02 -> 0x1D, 0x53*0xCA -> 0x8F (checked against the model), latency 8 cycles.
